matrix_mac_engine: RTL and testbench

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/matrix_mac_pkg.sv | 40 ++++
 rtl/matrix_mac_engine_mac_cell.sv | 34 +++
 rtl/matrix_mac_engine.sv | 141 ++++++++++++++
 tb/tb_matrix_mac_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mac_pkg.sv
// Shared types and helpers for the matrix multiply-accumulate engine:
// FSM state encoding and width-parameterised range check / clamp.
package matrix_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Working width for range checks; must cover the accumulator width.
    localparam int MAX_W = 128;

    // Largest signed value representable in w bits.
    function automatic logic signed [MAX_W-1:0] max_of(input int w);
        return $signed((MAX_W'(1) << (w - 1)) - MAX_W'(1));
    endfunction

    // Smallest signed value representable in w bits.
    function automatic logic signed [MAX_W-1:0] min_of(input int w);
        return -$signed(MAX_W'(1) << (w - 1));
    endfunction

    // True when v sign-fits in w bits.
    function automatic logic fits_width(input logic signed [MAX_W-1:0] v, input int w);
        return (v <= max_of(w)) && (v >= min_of(w));
    endfunction

    // Clamp v into the signed w-bit range.
    function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] v,
                                                         input int w);
        if (v > max_of(w)) begin
            return max_of(w);
        end else if (v < min_of(w)) begin
            return min_of(w);
        end
        return v;
    endfunction

endpackage

// File: rtl/matrix_mac_engine_mac_cell.sv
// One signed multiply-accumulate lane: acc += a*b with synchronous clear,
// hold when mac_en is low, and a global clock enable.
module mac_cell #(
    parameter int WIDTH_BIT = 32,
    parameter int ACC_WIDTH = 67
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        ena,
    input  logic                        clr,
    input  logic                        mac_en,
    input  logic signed [WIDTH_BIT-1:0] a,
    input  logic signed [WIDTH_BIT-1:0] b,
    output logic signed [ACC_WIDTH-1:0] acc
);

    // Full-precision product; sign-extended into the accumulator below.
    logic signed [2*WIDTH_BIT-1:0] prod;
    assign prod = a * b;

    // Accumulator: reset > clear > accumulate > hold.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            acc <= '0;
        end else if (ena) begin
            if (clr) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc + ACC_WIDTH'(prod);
            end
        end
    end

endmodule

// File: rtl/matrix_mac_engine.sv
// Matrix multiply-accumulate engine: O = sat(acc (+)= A*B), one inner-product
// step per enabled cycle across all AROWS*BCOLUMNS lanes in parallel.
//
// Handshake: an operand pair is taken on a rising edge where in_valid and
// in_ready are both high (in_ready is only high in IDLE with ena=1). A result
// is taken on a rising edge where out_valid, out_ready and ena are high;
// MatrixO/overflow are stable for as long as out_valid is high.
module matrix_mac_engine import matrix_mac_pkg::*; #(
    parameter int AROWS     = 3,
    parameter int ACOLUMNS  = 3,
    parameter int BCOLUMNS  = 3,
    parameter int WIDTH_BIT = 32,
    parameter int ACC_WIDTH = 2*WIDTH_BIT + $clog2(ACOLUMNS) + 1,
    parameter int SATURATE  = 1
) (
    input  logic                                          clock,
    input  logic                                          nreset,
    input  logic                                          ena,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [AROWS-1:0][ACOLUMNS-1:0][WIDTH_BIT-1:0] MatrixA,
    input  logic [ACOLUMNS-1:0][BCOLUMNS-1:0][WIDTH_BIT-1:0] MatrixB,
    input  logic                                          acc_mode,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [AROWS-1:0][BCOLUMNS-1:0][WIDTH_BIT-1:0] MatrixO,
    output logic                                          overflow,
    output logic [1:0]                                    dbg_state
);

    localparam int KW = (ACOLUMNS > 1) ? $clog2(ACOLUMNS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(ACOLUMNS - 1);

    state_t state, state_nx;
    logic [KW-1:0] k;
    // Set once the last inner-product step is in the accumulators; the
    // following COMPUTE cycle registers the result from them.
    logic drain;
    logic accept, clr, mac_en, capture;

    logic [AROWS-1:0][ACOLUMNS-1:0][WIDTH_BIT-1:0]    a_q;
    logic [ACOLUMNS-1:0][BCOLUMNS-1:0][WIDTH_BIT-1:0] b_q;
    logic [AROWS-1:0][BCOLUMNS-1:0][WIDTH_BIT-1:0]    res_d;
    logic [AROWS*BCOLUMNS-1:0]                        ovf;

    // State register; reset wins over ena.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (in_valid) state_nx = ST_COMPUTE;
            ST_COMPUTE: if (drain)    state_nx = ST_DONE;
            ST_DONE:    if (out_ready) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Output / control decode from the current state.
    always_comb begin
        in_ready  = (state == ST_IDLE) && ena;
        out_valid = (state == ST_DONE);
        accept    = in_valid && in_ready;
        clr       = accept && !acc_mode;
        mac_en    = (state == ST_COMPUTE) && !drain;
        capture   = (state == ST_COMPUTE) && drain;
    end

    // Operand latch, inner-product index and drain flag.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            k     <= '0;
            drain <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (ena) begin
            if (accept) begin
                a_q   <= MatrixA;
                b_q   <= MatrixB;
                k     <= '0;
                drain <= 1'b0;
            end else if (mac_en) begin
                if (k == K_LAST) begin
                    k     <= '0;
                    drain <= 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
            end else if (capture) begin
                drain <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < AROWS; i++) begin : g_row
        for (genvar j = 0; j < BCOLUMNS; j++) begin : g_col
            logic signed [ACC_WIDTH-1:0] acc;
            logic signed [MAX_W-1:0]     wide;

            mac_cell #(
                .WIDTH_BIT (WIDTH_BIT),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_cell (
                .clock  (clock),
                .nreset (nreset),
                .ena    (ena),
                .clr    (clr),
                .mac_en (mac_en),
                .a      (a_q[i][k]),
                .b      (b_q[k][j]),
                .acc    (acc)
            );

            assign wide = MAX_W'(acc);
            assign ovf[i*BCOLUMNS + j] = ~fits_width(wide, WIDTH_BIT);
            assign res_d[i][j] = (SATURATE != 0) ? WIDTH_BIT'(saturate(wide, WIDTH_BIT))
                                                 : acc[WIDTH_BIT-1:0];
        end
    end

    // Result register, loaded once per operation from the final accumulators.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            MatrixO  <= '0;
            overflow <= 1'b0;
        end else if (ena && capture) begin
            MatrixO  <= res_d;
            overflow <= |ovf;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: a 32-bit saturating instance and an 8-bit
// saturating instance run in lockstep on shared control, each checked by a
// queue-based scoreboard against an arithmetic reference model.
module tb_matrix_mac_engine;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT signals ----------------
    logic ena = 1'b1, in_valid = 1'b0, acc_mode = 1'b0, out_ready = 1'b0;
    logic [2:0][2:0][31:0] a0, b0, o0;
    logic [2:0][2:0][7:0]  a1, b1, o1;
    logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [1:0] st0, st1;

    matrix_mac_engine #(.WIDTH_BIT(32), .SATURATE(1)) dut0 (
        .clock(clock), .nreset(nreset), .ena(ena), .in_valid(in_valid),
        .in_ready(in_ready0), .MatrixA(a0), .MatrixB(b0), .acc_mode(acc_mode),
        .out_valid(out_valid0), .out_ready(out_ready), .MatrixO(o0),
        .overflow(ovf0), .dbg_state(st0));

    matrix_mac_engine #(.WIDTH_BIT(8), .SATURATE(1)) dut1 (
        .clock(clock), .nreset(nreset), .ena(ena), .in_valid(in_valid),
        .in_ready(in_ready1), .MatrixA(a1), .MatrixB(b1), .acc_mode(acc_mode),
        .out_valid(out_valid1), .out_ready(out_ready), .MatrixO(o1),
        .overflow(ovf1), .dbg_state(st1));

    // ---------------- scoreboard ----------------
    logic [288:0] exp0_q[$];
    logic [72:0]  exp1_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a result is consumed on the coming edge, compare it now.
    always @(negedge clock) begin
        if (nreset && ena && out_ready) begin
            if (out_valid0) begin
                if (exp0_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb0_unexpected actual=result required=none");
                end else begin
                    check("sb0_result", {ovf0, o0}, exp0_q.pop_front());
                end
            end
            if (out_valid1) begin
                if (exp1_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb1_unexpected actual=result required=none");
                end else begin
                    check("sb1_result", {ovf1, o1}, exp1_q.pop_front());
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic signed [127:0] m0[3][3];
    logic signed [127:0] m1[3][3];

    function automatic logic signed [127:0] clamp(input logic signed [127:0] v, input int w);
        logic signed [127:0] lim;
        lim = 128'sd1 <<< (w - 1);
        if (v >= lim) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                m0[i][j] = '0;
                m1[i][j] = '0;
            end
    endtask

    // O += A*B over plain integers, then clamp each element.
    task automatic model_issue(input logic mode);
        logic [288:0] e0;
        logic [72:0]  e1;
        logic signed [127:0] c;
        e0 = '0;
        e1 = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                if (!mode) begin
                    m0[i][j] = '0;
                    m1[i][j] = '0;
                end
                for (int kk = 0; kk < 3; kk++) begin
                    m0[i][j] += 128'($signed(a0[i][kk])) * 128'($signed(b0[kk][j]));
                    m1[i][j] += 128'($signed(a1[i][kk])) * 128'($signed(b1[kk][j]));
                end
                c = clamp(m0[i][j], 32);
                e0[(i*3+j)*32 +: 32] = c[31:0];
                if (c != m0[i][j]) e0[288] = 1'b1;
                c = clamp(m1[i][j], 8);
                e1[(i*3+j)*8 +: 8] = c[7:0];
                if (c != m1[i][j]) e1[72] = 1'b1;
            end
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
    endtask

    typedef int vals_t[9];
    function automatic logic [288:0] pack32(input vals_t v, input logic ov);
        logic [288:0] r;
        r = '0;
        for (int n = 0; n < 9; n++) r[n*32 +: 32] = v[n];
        r[288] = ov;
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_seq();
        for (int i = 0; i < 3; i++)
            for (int kk = 0; kk < 3; kk++) begin
                a0[i][kk] = 32'(i*3 + kk + 1);
                b0[i][kk] = 32'(9 - (i*3 + kk));
                a1[i][kk] = 8'(i*3 + kk + 1);
                b1[i][kk] = 8'(9 - (i*3 + kk));
            end
    endtask

    // Issue one operation, check latency, optionally stall the consumer,
    // then consume with in_valid high to confirm no same-cycle re-accept.
    task automatic do_op(input logic mode, input int hold, input int gap_len,
                         input logic [288:0] hold_exp, input logic chk_hold,
                         output logic [288:0] got0, output logic [72:0] got1);
        int guard;
        int cnt;
        acc_mode = mode;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready0 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
        model_issue(mode);
        cnt = 0;
        while (!out_valid0 && cnt < 40) begin
            ena = !(cnt >= 1 && cnt < 1 + gap_len);
            tick();
            cnt++;
            if (!ena) check("ready_low_when_disabled", in_ready0, 0);
        end
        ena = 1'b1;
        check("latency", cnt, 4 + gap_len);
        check("lockstep_valid", out_valid1, 1);
        got0 = {ovf0, o0};
        got1 = {ovf1, o1};
        for (int h = 0; h < hold; h++) begin
            tick();
            if (chk_hold) check("hold_stable", {ovf0, o0}, hold_exp);
            check("hold_valid", out_valid0, 1);
            check("hold_not_ready", in_ready0, 0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        check("consumed_idle", st0, 0);
        check("consumed_valid_low", out_valid0, 0);
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    vals_t v36 = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    vals_t v37 = '{60, 48, 36, 168, 138, 108, 276, 228, 180};

    initial begin
        logic [288:0] g0;
        logic [72:0]  g1;
        logic mode;
        int chain;

        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        model_clear();
        nreset = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        check("rst_out_valid", out_valid0, 0);
        check("rst_in_ready", in_ready0, 1);
        check("rst_matrix0", {ovf0, o0}, 0);
        check("rst_matrix1", {ovf1, o1}, 0);
        check("rst_state", st0, 0);

        // Fresh product, then accumulate the same operands.
        load_seq();
        do_op(1'b0, 0, 0, '0, 1'b0, g0, g1);
        check("fresh_product", g0, pack32(v36, 1'b0));
        do_op(1'b1, 0, 0, '0, 1'b0, g0, g1);
        check("accumulate", g0, pack32(v37, 1'b0));

        // Consumer stalls for 5 cycles.
        do_op(1'b0, 5, 0, pack32(v36, 1'b0), 1'b1, g0, g1);

        // Clock enable dropped for 3 cycles mid-compute.
        do_op(1'b0, 0, 3, '0, 1'b0, g0, g1);
        check("ena_gap_result", g0, pack32(v36, 1'b0));

        // Reset while k=1: no result, accumulators cleared.
        acc_mode = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        model_clear();
        check("abort_out_valid", out_valid0, 0);
        check("abort_in_ready", in_ready0, 1);
        check("abort_state", st0, 0);
        do_op(1'b1, 0, 0, '0, 1'b0, g0, g1);
        check("after_abort", g0, pack32(v36, 1'b0));

        // 8-bit lane saturation both directions.
        for (int i = 0; i < 3; i++)
            for (int kk = 0; kk < 3; kk++) begin
                a1[i][kk] = 8'd100;
                b1[i][kk] = 8'd100;
            end
        do_op(1'b0, 0, 0, '0, 1'b0, g0, g1);
        check("sat_pos", g1, {1'b1, {9{8'h7f}}});
        for (int i = 0; i < 3; i++)
            for (int kk = 0; kk < 3; kk++) a1[i][kk] = 8'h9c;
        do_op(1'b0, 0, 0, '0, 1'b0, g0, g1);
        check("sat_neg", g1, {1'b1, {9{8'h80}}});

        // Randomised operations, accumulate chains capped to stay in range.
        chain = 0;
        for (int n = 0; n < 40; n++) begin
            logic big;
            big = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++)
                for (int kk = 0; kk < 3; kk++) begin
                    a0[i][kk] = big ? $urandom() : 32'($urandom_range(0, 2000)) - 32'd1000;
                    b0[i][kk] = big ? $urandom() : 32'($urandom_range(0, 2000)) - 32'd1000;
                    a1[i][kk] = 8'($urandom_range(0, 255));
                    b1[i][kk] = 8'($urandom_range(0, 255));
                end
            mode = (n == 0 || chain >= 3) ? 1'b0 : 1'($urandom_range(0, 1));
            chain = mode ? chain + 1 : 0;
            do_op(mode, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 2 : 0,
                  '0, 1'b0, g0, g1);
        end

        repeat (3) tick();
        check("sb0_drained", exp0_q.size(), 0);
        check("sb1_drained", exp1_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
